// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer: fade-state encodings and the
// default duty word width.
package pwm_pkg;

  localparam int DUTY_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_t;

endpackage

// File: rtl/fade_tick_gen.sv
// Update-tick prescaler for the fade sequencer: counts 0..TICK_DIV-1 while
// enabled and flags the last count; held at zero while disabled or cleared.
module fade_tick_gen #(
  parameter int TICK_DIV = 1200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing duty-cycle sequencer for pwm_gen. Define PWM_FADE_HOLD_EN to build
// the HOLD state that dwells HOLD_TICKS ticks at the upper bound.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH      = DUTY_WIDTH,
  parameter int STEP       = 4,
  parameter int TICK_DIV   = 1200,
  parameter int HOLD_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] duty_min,
  input  logic [WIDTH-1:0] duty_max,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  fade_state_t      state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             stop_req;
  logic             tick;
  logic             start_ok;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   down_floor;
  logic             at_top;
  logic             at_bottom;

`ifdef PWM_FADE_HOLD_EN
  localparam int HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  // The first ramp-down tick is counted as the last dwell tick at max.
  localparam fade_state_t PEAK_STATE = (HOLD_TICKS > 1) ? HOLD : RAMP_DOWN;
  logic [HC_W-1:0] hold_cnt;
`else
  localparam fade_state_t PEAK_STATE = RAMP_DOWN;
`endif

  assign start_ok = (state == IDLE) && start && !stop;

  // One bit of headroom so neither direction can wrap before saturation.
  assign up_sum     = {1'b0, duty_cycle} + STEP_W;
  assign down_floor = {1'b0, lo} + STEP_W;
  assign at_top     = up_sum >= {1'b0, hi};
  assign at_bottom  = {1'b0, duty_cycle} <= down_floor;

  fade_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .clr (start_ok),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      duty_cycle <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stop_req   <= 1'b0;
      lo         <= '0;
      hi         <= '0;
`ifdef PWM_FADE_HOLD_EN
      hold_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (busy && stop) begin
        stop_req <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            lo         <= duty_min;
            hi         <= duty_max;
            duty_cycle <= duty_min;
            if (duty_min >= duty_max) begin
              done <= 1'b1;
            end else begin
              busy     <= 1'b1;
              stop_req <= 1'b0;
              state    <= RAMP_UP;
            end
          end
        end
        RAMP_UP: begin
          if (tick) begin
            if (stop_req) begin
              state <= RAMP_DOWN;
            end else if (at_top) begin
              duty_cycle <= hi;
              state      <= PEAK_STATE;
`ifdef PWM_FADE_HOLD_EN
              hold_cnt   <= HC_W'(HOLD_TICKS - 1);
`endif
            end else begin
              duty_cycle <= up_sum[WIDTH-1:0];
            end
          end
        end
`ifdef PWM_FADE_HOLD_EN
        HOLD: begin
          if (tick) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (stop_req || hold_cnt <= HC_W'(1)) begin
              state <= RAMP_DOWN;
            end
          end
        end
`endif
        RAMP_DOWN: begin
          if (tick) begin
            if (at_bottom) begin
              duty_cycle <= lo;
              if (stop_req) begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                stop_req <= 1'b0;
              end else begin
                state <= RAMP_UP;
              end
            end else begin
              duty_cycle <= duty_cycle - STEP_N;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: two instances (STEP=64 and STEP=50, TICK_DIV=4)
// checked every cycle against a direction/dwell model plus literal sequences.
module tb_pwm_fade_ctrl;

  localparam int TD = 4;
  localparam int HT = 2;
`ifdef PWM_FADE_HOLD_EN
  localparam int DWELL = HT - 1;
`else
  localparam int DWELL = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] duty_min;
  logic [7:0] duty_max;
  logic [7:0] duty_o [2];
  logic       busy_o [2];
  logic       done_o [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  int steps [2] = '{64, 50};
  int m_duty [2] = '{0, 0};
  int m_busy [2] = '{0, 0};
  int m_done [2] = '{0, 0};
  int m_up   [2] = '{0, 0};
  int m_stop [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  int m_dwell[2] = '{0, 0};
  int m_lo   [2] = '{0, 0};
  int m_hi   [2] = '{0, 0};

  pwm_fade_ctrl #(.WIDTH(8), .STEP(64), .TICK_DIV(TD), .HOLD_TICKS(HT)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .duty_min(duty_min), .duty_max(duty_max),
    .duty_cycle(duty_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  pwm_fade_ctrl #(.WIDTH(8), .STEP(50), .TICK_DIV(TD), .HOLD_TICKS(HT)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .duty_min(duty_min), .duty_max(duty_max),
    .duty_cycle(duty_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is a direction flag, a dwell count at the top and a
  // cycle counter that yields one step every TD busy cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_duty[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_up[k] = 0;
        m_stop[k] = 0; m_cnt[k] = 0; m_dwell[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int old_stop;
        m_done[k] = 0;
        if (m_busy[k] == 0) begin
          if (start && !stop) begin
            m_lo[k] = int'(duty_min);
            m_hi[k] = int'(duty_max);
            m_duty[k] = m_lo[k];
            if (m_lo[k] >= m_hi[k]) begin
              m_done[k] = 1;
            end else begin
              m_busy[k] = 1; m_cnt[k] = 0; m_up[k] = 1; m_stop[k] = 0; m_dwell[k] = 0;
            end
          end
        end else begin
          old_stop = m_stop[k];
          if (stop) m_stop[k] = 1;
          if (m_cnt[k] != TD - 1) begin
            m_cnt[k]++;
          end else begin
            m_cnt[k] = 0;
            if (m_up[k] != 0) begin
              if (old_stop != 0) begin
                m_up[k] = 0;
              end else if (m_duty[k] + steps[k] >= m_hi[k]) begin
                m_duty[k] = m_hi[k]; m_up[k] = 0; m_dwell[k] = DWELL;
              end else begin
                m_duty[k] += steps[k];
              end
            end else if (m_dwell[k] > 0) begin
              m_dwell[k] = (old_stop != 0) ? 0 : m_dwell[k] - 1;
            end else if (m_duty[k] <= m_lo[k] + steps[k]) begin
              m_duty[k] = m_lo[k];
              if (old_stop != 0) begin
                m_busy[k] = 0; m_done[k] = 1; m_stop[k] = 0;
              end else begin
                m_up[k] = 1;
              end
            end else begin
              m_duty[k] -= steps[k];
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("duty%0d", k), int'(duty_o[k]), m_duty[k]);
        check($sformatf("busy%0d", k), int'(busy_o[k]), m_busy[k]);
        check($sformatf("done%0d", k), int'(done_o[k]), m_done[k]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_duty0(input int v, input bit need_up, input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (int'(duty_o[0]) == v && (!need_up || m_up[0] == 1)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, int'(ok), 1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_o[0] && !busy_o[1]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, int'(ok), 1);
  endtask

  initial begin
    int s0 [$];
    int s1 [$];
    int chg [$];
    int lit0 [8] = '{0, 64, 128, 192, 128, 64, 0, 64};
    int lit1 [9] = '{0, 50, 100, 150, 192, 142, 92, 42, 0};
    int prev;
    int dones;
    bit ended;

    rst = 1; start = 0; stop = 0; duty_min = 0; duty_max = 0;
    #2 rst = 0;
    repeat (3) @(negedge clk);
    check("reset_duty", int'(duty_o[0]), 0);
    check("reset_busy", int'(busy_o[0]), 0);
    check("reset_done", int'(done_o[0]), 0);
    chk_en = 1;
    rst = 1;
    repeat (2) @(negedge clk);

    // Basic ramp and saturation
    duty_min = 0; duty_max = 192;
    pulse_start();
    for (int i = 0; i < 36; i++) begin
      s0.push_back(int'(duty_o[0]));
      s1.push_back(int'(duty_o[1]));
      @(negedge clk);
    end
    check("basic_busy", int'(busy_o[0]), 1);
`ifndef PWM_FADE_HOLD_EN
    for (int k = 0; k < 8; k++) begin
      check($sformatf("basic_step%0d", k), s0[4*k], lit0[k]);
      check($sformatf("basic_hold%0d", k), s0[4*k+3], lit0[k]);
    end
    for (int k = 0; k < 9; k++) begin
      check($sformatf("sat_step%0d", k), s1[4*k], lit1[k]);
    end
`endif

    // Stop during ramp-up at 128
    wait_duty0(128, 1, "stop_reach128");
    stop = 1;
    @(negedge clk); stop = 0;
    prev = int'(duty_o[0]); dones = int'(done_o[0]); ended = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (int'(duty_o[0]) != prev) chg.push_back(int'(duty_o[0]));
      prev = int'(duty_o[0]);
      dones += int'(done_o[0]);
      if (!busy_o[0]) begin
        ended = 1;
        break;
      end
    end
    check("stop_ended", int'(ended), 1);
    check("stop_nchg", chg.size(), 2);
    if (chg.size() == 2) begin
      check("stop_chg0", chg[0], 64);
      check("stop_chg1", chg[1], 0);
    end
    repeat (8) begin
      @(negedge clk);
      dones += int'(done_o[0]);
    end
    check("stop_done_once", dones, 1);
    check("stop_duty_hold", int'(duty_o[0]), 0);
    wait_idle("stop_both_idle");

    // start and stop together in IDLE are ignored
    duty_min = 10; duty_max = 200;
    @(negedge clk); start = 1; stop = 1;
    @(negedge clk); start = 0; stop = 0;
    repeat (6) @(negedge clk);
    check("startstop_busy", int'(busy_o[0]), 0);
    check("startstop_duty", int'(duty_o[0]), 0);

    // Degenerate bounds
    duty_min = 100; duty_max = 100;
    pulse_start();
    check("degen_duty", int'(duty_o[0]), 100);
    check("degen_done", int'(done_o[0]), 1);
    check("degen_busy", int'(busy_o[0]), 0);
    @(negedge clk);
    check("degen_done_off", int'(done_o[0]), 0);

    // Start while busy and bound changes while busy are ignored
    duty_min = 0; duty_max = 192;
    pulse_start();
    duty_min = 50; duty_max = 60;
    repeat (4) @(negedge clk);
    pulse_start();
    wait_duty0(192, 0, "busy_start_ignored");

    // Asynchronous reset mid-sequence
    wait_duty0(128, 0, "rst_reach128");
    @(negedge clk);
    #1 rst = 0;
    #1;
    check("rst_duty", int'(duty_o[0]), 0);
    check("rst_busy", int'(busy_o[0]), 0);
    check("rst_done", int'(done_o[0]), 0);
    @(negedge clk); rst = 1;
    repeat (12) @(negedge clk);
    check("rst_stays_idle", int'(busy_o[0]), 0);

`ifdef PWM_FADE_HOLD_EN
    // Dwell at max
    begin
      int dwell_cyc = 0;
      duty_min = 0; duty_max = 192;
      pulse_start();
      wait_duty0(192, 0, "hold_reach192");
      for (int i = 0; i < 50 && int'(duty_o[0]) == 192; i++) begin
        dwell_cyc++;
        @(negedge clk);
      end
      check("hold_dwell", dwell_cyc, 8);
      check("hold_after", int'(duty_o[0]), 128);
    end
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Duty-cycle sequencer for `pwm_gen`. It drives the generator's `duty_cycle` input with a repeating "breathing" ramp between a programmable minimum and maximum. Each step is taken on an internal update tick derived from the system clock. A start/stop handshake controls the sequence, and on stop it always finishes at the minimum level. It sits between the control logic and `pwm_gen`, in place of a constant duty register.

## Interface
- `WIDTH`, 8: duty word width; must match `pwm_gen`.
- `STEP`, 4: duty increment/decrement per tick (1 ≤ STEP < 2^WIDTH).
- `TICK_DIV`, 1200: clk cycles per update tick (≥ 2).
- `HOLD_TICKS`, 16: ticks held at maximum; used only with `PWM_FADE_HOLD_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin the sequence.
- `stop`  in  1  one-cycle request to end the sequence.
- `duty_min`  in  WIDTH  lower ramp bound; sampled on an accepted start.
- `duty_max`  in  WIDTH  upper ramp bound; sampled on an accepted start.
- `duty_cycle`  out  WIDTH  duty word to `pwm_gen`; registered.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle pulse when the sequence ends.

## Operation
- States: IDLE, RAMP_UP, HOLD (exists only with the macro), RAMP_DOWN.
- Reset (`rst`=0): state IDLE, `duty_cycle`=0, `busy`=0, `done`=0, prescaler=0, stop_req=0.
- **Start in IDLE** with `start`=1 and `stop`=0:
  - Latch min/max.
  - If min ≥ max: `duty_cycle`=min, pulse `done`, remain IDLE.
  - Otherwise: `duty_cycle`=min, `busy`=1, prescaler cleared, go to RAMP_UP.
- `start` and `stop` together in IDLE: both ignored.
- `start` while busy: ignored.
- `stop` in IDLE: ignored.
- `stop` while busy sets stop_req; stop_req stays set until the sequence ends.
- Prescaler:
  - Counts 0..TICK_DIV-1 while busy and raises tick at TICK_DIV-1.
  - Held at 0 in IDLE.
- RAMP_UP, on tick:
  - If stop_req: go to RAMP_DOWN with no duty change.
  - Else if duty+STEP ≥ max: duty=max, then go to HOLD (macro) or RAMP_DOWN.
  - Else duty += STEP.
- HOLD, on tick:
  - Decrement the hold counter.
  - Go to RAMP_DOWN after HOLD_TICKS ticks, or immediately if stop_req is set.
- RAMP_DOWN, on tick:
  - If duty ≤ min+STEP: duty=min.
    - If stop_req: go to IDLE, `busy`=0, pulse `done`, clear stop_req.
    - Else go to RAMP_UP.
  - Otherwise duty −= STEP.
- Arithmetic:
  - Computed at WIDTH+1 bits, so no wrap-around is possible.
  - Results are saturated to the latched bounds.
- After a sequence ends, `duty_cycle` holds min until the next start.

## Timing
- An accepted start updates `duty_cycle`/`busy` on the next clk edge.
- The first step occurs TICK_DIV cycles after `busy` rises.
- Every duty change occurs exactly on a tick edge, one change per tick.
- `done` is high for exactly one cycle, the same cycle `busy` falls (or, for the min ≥ max case, the cycle after start).
- Asserting `rst` mid-sequence immediately forces all reset values; no `done` pulse is generated.
- min/max input changes while busy have no effect.

## Configuration
- `PWM_FADE_HOLD_EN` defined:
  - HOLD state and hold counter are built.
  - The ramp dwells HOLD_TICKS ticks at max.
- Not defined:
  - No HOLD state.
  - RAMP_UP goes to RAMP_DOWN directly on reaching max.
  - HOLD_TICKS is unused.

## Structure
- Shared package `pwm_pkg`: fade-state encodings (IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3) and the default duty width constant.
- Sub-module `fade_tick_gen`:
  - Parameter TICK_DIV.
  - Inputs `clk`, `rst`, `en`, `clr`; output `tick`.
  - Holds the prescaler.
- The FSM, duty arithmetic and hold counter live in `pwm_fade_ctrl`.

## Test plan
- **Basic ramp.** TICK_DIV=4, STEP=64, min=0, max=192, macro off; start → `duty_cycle` 0,64,128,192,128,64,0,64… with one change every 4 cycles; `busy`=1.
- **Saturation.** STEP=50, min=0, max=192; ramp reads 0,50,100,150,192,142,92,42,0, never wrapping.
- **Stop during RAMP_UP.** Stop at duty=128 → next tick begins descent 128,64,0; then `busy`=0 and `done` pulses exactly once; `duty_cycle` holds 0.
- **Hold.** Macro on, HOLD_TICKS=2, TICK_DIV=4; `duty_cycle` stays 192 for 8 cycles before dropping to 128.
- **Degenerate and ignored requests.**
  - min=100, max=100: start gives `duty_cycle`=100, `done` pulse, `busy` stays 0.
  - start+stop in the same cycle in IDLE: no change.
  - start while busy: ignored.
- **Reset mid-sequence.** Drive `rst` low at duty=128 → asynchronously `duty_cycle`=0, `busy`=0, `done`=0; after release the block stays IDLE until the next start.
